// File: rtl/serial_tx_framer.sv
// Purpose : parallel-to-serial transmit framer: start bit, data LSB first, optional even parity, stop bit.
// Latency : SOUT goes to the start level on the accepting edge; frame lasts (2+DATA_WIDTH+PARITY_EN)*BIT_CYCLES cycles.
// Backpress: READY_OUT is high only in IDLE; a word is taken on VALID_IN & READY_OUT, one frame at a time.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   DATA_IN    parallel word to transmit (sampled only on acceptance)
//   VALID_IN   DATA_IN is valid
//   READY_OUT  framer idle and able to accept a word
//   SOUT       registered serial line, idles at 1
//   BUSY       frame in progress
//   DONE       one-cycle pulse in the first idle cycle after a frame

module serial_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int BIT_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  VALID_IN,
  output logic                  READY_OUT,
  output logic                  SOUT,
  output logic                  BUSY,
  output logic                  DONE
);

  // Counter widths never collapse to zero bits, even for single-cycle bits
  // or single-bit payloads.
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cyc_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_bit;

  logic                    bit_end;
  logic [DATA_WIDTH-1:0]   shreg_nxt;

  // Last cycle of the bit currently on the line.
  assign bit_end   = (cyc_cnt == CYC_LAST);
  assign shreg_nxt = shreg >> 1;

  // Handshake status decodes straight from the registered state so there is
  // no combinational path from VALID_IN to READY_OUT.
  assign READY_OUT = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);

  // SOUT is always loaded with the level of the bit that the state being
  // entered (or held) represents, so the line changes on the same edge as
  // the state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      SOUT    <= 1'b1;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          SOUT    <= 1'b1;
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (VALID_IN) begin
            shreg   <= DATA_IN;
            par_bit <= ^DATA_IN;
            SOUT    <= 1'b0;
            state   <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            SOUT    <= shreg[0];
            state   <= ST_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            shreg   <= shreg_nxt;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                SOUT  <= par_bit;
                state <= ST_PARITY;
              end else begin
                SOUT  <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // Drive the next LSB now; the shift lands on this same edge.
              SOUT    <= shreg_nxt[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            SOUT    <= 1'b1;
            state   <= ST_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          SOUT <= 1'b1;
          if (bit_end) begin
            cyc_cnt <= '0;
            DONE    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          SOUT    <= 1'b1;
          cyc_cnt <= '0;
          bit_cnt <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Purpose : directed self-checking bench for serial_tx_framer in three parameterisations.
// Latency : inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpress: handshakes are issued only when READY_OUT is expected high.

module tb_serial_tx_framer;

  logic clk;
  logic rst_n;

  // Instance 0: defaults (8 data bits, parity on, 1 cycle per bit)
  logic [7:0] d0;
  logic       v0, r0, s0, b0, dn0;
  // Instance 1: parity off
  logic [7:0] d1;
  logic       v1, r1, s1, b1, dn1;
  // Instance 2: 4 cycles per bit
  logic [7:0] d2;
  logic       v2, r2, s2, b2, dn2;

  int vectors;
  int miscompares;

  serial_tx_framer #(.DATA_WIDTH(8), .PARITY_EN(1), .BIT_CYCLES(1)) u_dut0 (
    .CLK(clk), .RST(rst_n), .DATA_IN(d0), .VALID_IN(v0),
    .READY_OUT(r0), .SOUT(s0), .BUSY(b0), .DONE(dn0)
  );

  serial_tx_framer #(.DATA_WIDTH(8), .PARITY_EN(0), .BIT_CYCLES(1)) u_dut1 (
    .CLK(clk), .RST(rst_n), .DATA_IN(d1), .VALID_IN(v1),
    .READY_OUT(r1), .SOUT(s1), .BUSY(b1), .DONE(dn1)
  );

  serial_tx_framer #(.DATA_WIDTH(8), .PARITY_EN(1), .BIT_CYCLES(4)) u_dut2 (
    .CLK(clk), .RST(rst_n), .DATA_IN(d2), .VALID_IN(v2),
    .READY_OUT(r2), .SOUT(s2), .BUSY(b2), .DONE(dn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset held with VALID_IN high: everything idles and nothing is taken.
  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
    d0 = 8'hFF; d1 = 8'hFF; d2 = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({s0, r0, b0, dn0} !== 4'b1100) begin
        miscompares++;
        $display("FAIL reset_dut0 cycle %0d: got {sout,rdy,busy,done}=%b want 1100", c, {s0, r0, b0, dn0});
      end
      vectors++;
      if ({s1, r1, b1, dn1, s2, r2, b2, dn2} !== 8'b1100_1100) begin
        miscompares++;
        $display("FAIL reset_dut12 cycle %0d: got %b want 11001100", c, {s1, r1, b1, dn1, s2, r2, b2, dn2});
      end
    end
    rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s0, r0, b0, dn0} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_release: got {sout,rdy,busy,done}=%b want 1100", {s0, r0, b0, dn0});
    end
  endtask

  // Defaults, 0xA5: start, 1,0,1,0,0,1,0,1, parity 0, stop.
  task automatic test_basic();
    logic [10:0] exp;
    exp = 11'b0_10100101_0_1;
    @(negedge clk);
    d0 = 8'hA5; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      vectors++;
      if ({s0, r0, b0, dn0} !== {exp[10-c], 3'b010}) begin
        miscompares++;
        $display("FAIL basic cycle %0d: got {sout,rdy,busy,done}=%b want %b", c, {s0, r0, b0, dn0}, {exp[10-c], 3'b010});
      end
    end
    @(negedge clk);
    vectors++;
    if ({s0, r0, b0, dn0} !== 4'b1101) begin
      miscompares++;
      $display("FAIL basic_done: got {sout,rdy,busy,done}=%b want 1101", {s0, r0, b0, dn0});
    end
    @(negedge clk);
    vectors++;
    if ({s0, r0, b0, dn0} !== 4'b1100) begin
      miscompares++;
      $display("FAIL basic_done_clear: got {sout,rdy,busy,done}=%b want 1100", {s0, r0, b0, dn0});
    end
  endtask

  // Parity disabled, 0x07: start, 1,1,1,0,0,0,0,0, stop.
  task automatic test_no_parity();
    logic [9:0] exp;
    exp = 10'b0_11100000_1;
    @(negedge clk);
    d1 = 8'h07; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      vectors++;
      if ({s1, r1, b1, dn1} !== {exp[9-c], 3'b010}) begin
        miscompares++;
        $display("FAIL no_parity cycle %0d: got {sout,rdy,busy,done}=%b want %b", c, {s1, r1, b1, dn1}, {exp[9-c], 3'b010});
      end
    end
    @(negedge clk);
    vectors++;
    if ({s1, r1, b1, dn1} !== 4'b1101) begin
      miscompares++;
      $display("FAIL no_parity_done: got {sout,rdy,busy,done}=%b want 1101", {s1, r1, b1, dn1});
    end
  endtask

  // Four cycles per bit, 0x01: start, 1, seven 0s, parity 1, stop -> 44 cycles.
  task automatic test_bit_cycles();
    logic [10:0] exp;
    exp = 11'b0_10000000_1_1;
    @(negedge clk);
    d2 = 8'h01; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    d2 = 8'hFE;
    for (int c = 0; c < 44; c++) begin
      if (c > 0) @(negedge clk);
      vectors++;
      if ({s2, r2, b2, dn2} !== {exp[10-c/4], 3'b010}) begin
        miscompares++;
        $display("FAIL bit_cycles cycle %0d: got {sout,rdy,busy,done}=%b want %b", c, {s2, r2, b2, dn2}, {exp[10-c/4], 3'b010});
      end
    end
    @(negedge clk);
    vectors++;
    if ({s2, r2, b2, dn2} !== 4'b1101) begin
      miscompares++;
      $display("FAIL bit_cycles_done: got {sout,rdy,busy,done}=%b want 1101", {s2, r2, b2, dn2});
    end
  endtask

  // VALID_IN held high: 0x3C then 0xC3, second start exactly 12 cycles later.
  // DATA_IN is disturbed during the first frame, which must stay 0x3C.
  task automatic test_back_to_back();
    logic [10:0] exp1;
    logic [10:0] exp2;
    logic [3:0]  want;
    exp1 = 11'b0_00111100_0_1;
    exp2 = 11'b0_11000011_0_1;
    @(negedge clk);
    d0 = 8'h3C; v0 = 1'b1;
    @(negedge clk);
    d0 = 8'h00;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 11)       want = {exp1[10-c], 3'b010};
      else if (c == 11) want = 4'b1101;
      else if (c < 23)  want = {exp2[22-c], 3'b010};
      else              want = 4'b1101;
      vectors++;
      if ({s0, r0, b0, dn0} !== want) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got {sout,rdy,busy,done}=%b want %b", c, {s0, r0, b0, dn0}, want);
      end
      if (c == 6)  d0 = 8'hC3;
      if (c == 12) v0 = 1'b0;
    end
  endtask

  // Reset during the data phase of an all-zero word, then a clean 0x5A frame.
  task automatic test_reset_mid_frame();
    logic [10:0] exp;
    exp = 11'b0_01011010_0_1;
    @(negedge clk);
    d0 = 8'h00; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      vectors++;
      if ({s0, r0, b0, dn0} !== 4'b0010) begin
        miscompares++;
        $display("FAIL abort_pre cycle %0d: got {sout,rdy,busy,done}=%b want 0010", c, {s0, r0, b0, dn0});
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({s0, r0, b0, dn0} !== 4'b1100) begin
      miscompares++;
      $display("FAIL abort_async: got {sout,rdy,busy,done}=%b want 1100", {s0, r0, b0, dn0});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if ({s0, r0, b0, dn0} !== 4'b1100) begin
        miscompares++;
        $display("FAIL abort_idle cycle %0d: got {sout,rdy,busy,done}=%b want 1100", c, {s0, r0, b0, dn0});
      end
    end
    d0 = 8'h5A; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      vectors++;
      if (c < 11) begin
        if ({s0, r0, b0, dn0} !== {exp[10-c], 3'b010}) begin
          miscompares++;
          $display("FAIL after_abort cycle %0d: got {sout,rdy,busy,done}=%b want %b", c, {s0, r0, b0, dn0}, {exp[10-c], 3'b010});
        end
      end else begin
        if ({s0, r0, b0, dn0} !== 4'b1101) begin
          miscompares++;
          $display("FAIL after_abort_done: got {sout,rdy,busy,done}=%b want 1101", {s0, r0, b0, dn0});
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;

    test_reset();
    test_basic();
    test_no_parity();
    test_bit_cycles();
    test_back_to_back();
    test_reset_mid_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
